// File: rtl/ksa_share_ctrl.sv
// rtl/ksa_share_ctrl.sv - round-robin sequencer sharing one WIDTH-bit adder across two requesters
module ksa_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [WIDTH*WORDS-1:0] req0_a,
    input  logic [WIDTH*WORDS-1:0] req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [WIDTH*WORDS-1:0] req1_a,
    input  logic [WIDTH*WORDS-1:0] req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [WIDTH*WORDS-1:0] rsp_sum,
    output logic                   rsp_cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int W  = WIDTH * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   sum_reg;
    logic           carry;
    logic           id;
    logic           last_grant;
    logic [KW-1:0]  k;
    logic           rsp_valid_q;
    logic           grant0;
    logic           grant1;
    logic [31:0]    base;

    assign base = 32'(k) * 32'(WIDTH);

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last time
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Present the current slice to the shared adder only while running; idle the adder otherwise
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[base +: WIDTH];
            add_b   = b_reg[base +: WIDTH];
            add_cin = carry;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_reg;
    assign rsp_cout  = carry;
    assign rsp_id    = id;

    // Sequencer: capture on grant, walk slices LSB first chaining the carry, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry       <= 1'b0;
            id          <= 1'b0;
            last_grant  <= 1'b1;
            k           <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg      <= grant1 ? req1_a : req0_a;
                        b_reg      <= grant1 ? req1_b : req0_b;
                        carry      <= grant1 ? req1_cin : req0_cin;
                        id         <= grant1;
                        last_grant <= grant1;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base +: WIDTH] <= add_sum;
                    carry                  <= add_cout;
                    if (k == K_LAST) begin
                        state       <= DONE;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
